// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths, channel indices and select decode for result_router
package router_pkg;

    localparam int DATA_W    = 24;
    localparam int N_OUT     = 4;
    localparam int SEL_W     = 2;
    localparam int BUF_DEPTH = 2;

    // Consumer assignment of each output channel
    localparam logic [SEL_W-1:0] CH_WB    = 2'd0;
    localparam logic [SEL_W-1:0] CH_STORE = 2'd1;
    localparam logic [SEL_W-1:0] CH_BR    = 2'd2;
    localparam logic [SEL_W-1:0] CH_DBG   = 2'd3;

    // One-hot decode of a channel select
    function automatic logic [N_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [N_OUT-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/route_fifo2.sv
// rtl/route_fifo2.sv - two-entry synchronous FIFO used as one router output channel
module route_fifo2
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic              wptr;
    logic              rptr;
    logic [1:0]        cnt;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Head is read straight from storage; entries are never cleared on pop
    assign rdata = mem[rptr];

    // Pointer/count bookkeeping; with one entry held, push+pop moves the head onto the new word
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 2'd0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            cnt  <= 2'd0;
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (pop_ok) begin
                rptr <= ~rptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/result_router.sv
// rtl/result_router.sv - 1-to-4 result router with a two-entry buffer per consumer
module result_router
    import router_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    busy
);

    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] empty;
    logic [N_OUT-1:0] push;
    logic [N_OUT-1:0] pop;
    logic             accept;

    // Readiness depends only on the selected channel's fill level, never on consumers
    assign in_ready = !reset && !flush && !full[in_sel];
    assign accept   = in_valid && in_ready;
    assign push     = sel_onehot(in_sel) & {N_OUT{accept}};

    // Consumers are ignored while a flush squashes the buffers
    assign pop = out_ready & out_valid & {N_OUT{!flush}};

    assign out_valid = ~empty;
    assign busy      = |out_valid;

    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        route_fifo2 u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (push[k]),
            .wdata (in_data),
            .pop   (pop[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .rdata (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule
